// File: rtl/unary_gen_pkg.sv
// Shared types and constants for the binary-to-unary stream generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package unary_gen_pkg;

  // Generator control state: waiting for an operand vector, or streaming one.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Default operand/RNG width and the matching stream length in beats.
  localparam int RWID_DEFAULT = 8;
  localparam int STREAM_LEN   = 1 << RWID_DEFAULT;

  // Stream length for an arbitrary operand width: one beat per RNG state.
  function automatic int stream_len(input int rwid);
    return 1 << rwid;
  endfunction

endpackage

// File: rtl/unary_cmp_lane.sv
// One lane of the unary generator: registered unsigned compare of operand vs RNG.
// Latency: result visible one clock after the enabled edge.
// Backpressure: output flop holds its value whenever en is low.
module unary_cmp_lane #(
  parameter int RWID = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [RWID-1:0] op,
  input  logic [RWID-1:0] rng,
  output logic            bit_q
);

  // Emit a one whenever the operand exceeds this beat's random value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else if (en) begin
      bit_q <= (op > rng);
    end
  end

endmodule

// File: rtl/unary_gen_array.sv
// Converts a latched vector of binary operands into 2^RWID-beat stochastic bitstreams.
// Latency: load at edge t, promote at t+1, first oValid after t+2; back-to-back streams gapless.
// Backpressure: oValid && !oReady holds oBit/oLast/cnt/acData and freezes the RNG (rngEn=0).
module unary_gen_array
  import unary_gen_pkg::*;
#(
  parameter int RWID = RWID_DEFAULT,
  parameter int BDIM = 2,
  parameter int SDIM = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             iValid,
  output logic                             iReady,
  input  logic [BDIM*SDIM-1:0][RWID-1:0]   iData,
  input  logic [BDIM*SDIM-1:0][RWID-1:0]   rngSeq,
  output logic                             rngEn,
  output logic [BDIM*SDIM-1:0]             oBit,
  output logic                             oValid,
  input  logic                             oReady,
  output logic                             oLast
);

  localparam int N = BDIM * SDIM;
  localparam logic [RWID-1:0] LAST_BEAT = RWID'(stream_len(RWID) - 1);

  state_t                   state;
  logic                     sh_full;
  logic [N-1:0][RWID-1:0]   sh_data;
  logic [N-1:0][RWID-1:0]   ac_data;
  logic [RWID-1:0]          cnt;
  logic                     adv;
  logic                     last_beat;

  // The shadow slot is the only input buffer; it is free whenever it is empty.
  assign iReady    = !sh_full;

  // A beat is produced whenever streaming and the output slot is empty or draining.
  assign adv       = (state == RUN) && (!oValid || oReady);
  assign last_beat = (cnt == LAST_BEAT);

  // The RNG steps on the same edge that samples it, so each beat sees a fresh value
  // and a stalled output freezes the RNG sequence.
  assign rngEn     = adv;

  // Control: shadow load, promotion to active, beat counter and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh_full <= 1'b0;
      sh_data <= '0;
      ac_data <= '0;
      cnt     <= '0;
      oValid  <= 1'b0;
      oLast   <= 1'b0;
    end else begin
      // Load and promote never coincide: loading needs the shadow empty,
      // promoting needs it full.
      if (iValid && iReady) begin
        sh_data <= iData;
        sh_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sh_full) begin
            ac_data <= sh_data;
            sh_full <= 1'b0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (adv && last_beat) begin
            if (sh_full) begin
              // Counter wraps to zero on this advance, so the next stream
              // starts at beat 0 without a bubble.
              ac_data <= sh_data;
              sh_full <= 1'b0;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (adv) begin
        oValid <= 1'b1;
        oLast  <= last_beat;
        cnt    <= cnt + RWID'(1);
      end else if (oReady && oValid) begin
        oValid <= 1'b0;
        oLast  <= 1'b0;
      end
    end
  end

  // One registered comparator per lane, all stepped by the shared advance.
  for (genvar i = 0; i < N; i++) begin : g_lane
    unary_cmp_lane #(
      .RWID (RWID)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .op    (ac_data[i]),
      .rng   (rngSeq[i]),
      .bit_q (oBit[i])
    );
  end

endmodule

// File: tb/tb_unary_gen_array.sv
// Self-checking bench for unary_gen_array: table of operand vectors plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: oReady is driven by the bench to stall mid-stream.
module tb_unary_gen_array;
  import unary_gen_pkg::*;

  localparam int RWID = 8;
  localparam int BDIM = 2;
  localparam int SDIM = 8;
  localparam int N    = BDIM * SDIM;

  typedef logic [N-1:0][RWID-1:0] vec_t;

  typedef struct packed {
    logic [N-1:0] bits;
    logic         last;
  } beat_t;

  typedef struct {
    logic [RWID-1:0] a;
    logic [RWID-1:0] b;
    logic [RWID-1:0] rest;
    int              stall_beat;
    int              stall_len;
    logic [RWID-1:0] ea;
    logic [RWID-1:0] eb;
    logic [RWID-1:0] erest;
  } vec_rec_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic iValid = 1'b0;
  logic oReady = 1'b1;
  logic iReady, rngEn, oValid, oLast;
  vec_t iData  = '0;
  vec_t rngSeq;
  logic [N-1:0] oBit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unary_gen_array #(
    .RWID (RWID),
    .BDIM (BDIM),
    .SDIM (SDIM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .iValid (iValid),
    .iReady (iReady),
    .iData  (iData),
    .rngSeq (rngSeq),
    .rngEn  (rngEn),
    .oBit   (oBit),
    .oValid (oValid),
    .oReady (oReady),
    .oLast  (oLast)
  );

  // Full-period RNG model: a free-running counter mapped per lane through an
  // odd multiplier and offset, so 256 consecutive steps visit every value once.
  logic [RWID-1:0] rng_s = 8'h5A;
  always @(posedge clk) if (rngEn) rng_s <= rng_s + 8'd1;
  always_comb begin
    rngSeq = '0;
    for (int i = 0; i < N; i++) rngSeq[i] = rng_s * 8'd37 + 8'(i * 19);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  vec_t  op_q[$];     // accepted operand vectors, front = active stream
  vec_t  exp_q[$];    // expected per-lane ones counts, pushed when stimulus is driven
  beat_t beat_q[$];   // expected beats awaiting acceptance
  int    mbeat = 0;
  int    acc_beats = 0;
  int    streams_done = 0;
  int    ones[N];
  logic  cont_pending = 1'b0;
  logic  expect_cont = 1'b0;
  logic  prev_stall = 1'b0;
  logic [N:0] prev_out = '0;

  // Monitor: samples at the falling edge the values the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      op_q.delete(); exp_q.delete(); beat_q.delete();
      mbeat = 0; acc_beats = 0;
      for (int i = 0; i < N; i++) ones[i] = 0;
      cont_pending = 1'b0; expect_cont = 1'b0; prev_stall = 1'b0;
    end else begin
      if (expect_cont) check("b2b_no_gap", oValid, 1'b1);
      expect_cont = 1'b0;
      if (prev_stall) check("stall_hold", {oLast, oBit}, prev_out);
      if (oValid && !oReady) check("stall_rngen", rngEn, 1'b0);
      prev_stall = oValid && !oReady;
      prev_out   = {oLast, oBit};

      if (oValid && oReady) begin
        check("beat_expected", beat_q.size() > 0, 1'b1);
        if (beat_q.size() > 0) begin
          beat_t b;
          b = beat_q.pop_front();
          check("beat_bits", oBit, b.bits);
          check("beat_last", oLast, b.last);
        end
        acc_beats++;
        for (int i = 0; i < N; i++) ones[i] += int'(oBit[i]);
        if (oLast) begin
          check("stream_len", acc_beats, STREAM_LEN);
          check("exp_present", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            for (int i = 0; i < N; i++)
              check($sformatf("ones_lane%0d", i), ones[i], e[i]);
          end
          streams_done++;
          acc_beats = 0;
          for (int i = 0; i < N; i++) ones[i] = 0;
          expect_cont = cont_pending;
        end
      end

      if (rngEn) begin
        check("rngen_has_operand", op_q.size() > 0, 1'b1);
        if (op_q.size() > 0) begin
          beat_t b;
          for (int i = 0; i < N; i++) b.bits[i] = op_q[0][i] > rngSeq[i];
          b.last = (mbeat == STREAM_LEN - 1);
          beat_q.push_back(b);
          mbeat++;
          if (mbeat == STREAM_LEN) begin
            cont_pending = (op_q.size() > 1);
            mbeat = 0;
            void'(op_q.pop_front());
          end
        end
      end

      if (iValid && iReady) op_q.push_back(iData);
    end
  end

  function automatic vec_t mk(input logic [RWID-1:0] a, input logic [RWID-1:0] b,
                              input logic [RWID-1:0] rest);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = rest;
    v[0] = a;
    v[1] = b;
    return v;
  endfunction

  task automatic load(input vec_t v, input vec_t e);
    logic got;
    got = 1'b0;
    exp_q.push_back(e);
    iValid = 1'b1;
    iData  = v;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); got = iReady;
      @(posedge clk); #1;
      if (got) break;
    end
    iValid = 1'b0;
    check("load_accept", got, 1'b1);
    check("ready_low_after_load", iReady, 1'b0);
  endtask

  task automatic wait_streams(input int target, input int stall_beat, input int stall_len);
    int stalled;
    stalled = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (streams_done >= target) break;
      if (stall_len > 0 && acc_beats >= stall_beat && stalled < stall_len) begin
        oReady = 1'b0;
        stalled++;
      end else begin
        oReady = 1'b1;
      end
    end
    oReady = 1'b1;
    check("streams_done", streams_done >= target, 1'b1);
  endtask

  vec_rec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{a:8'd128, b:8'd128, rest:8'd128, stall_beat:0,  stall_len:0,  ea:8'd128, eb:8'd128, erest:8'd128};
    tbl[1] = '{a:8'd0,   b:8'd255, rest:8'd77,  stall_beat:0,  stall_len:0,  ea:8'd0,   eb:8'd255, erest:8'd77};
    tbl[2] = '{a:8'd128, b:8'd0,   rest:8'd200, stall_beat:50, stall_len:10, ea:8'd128, eb:8'd0,   erest:8'd200};
    tbl[3] = '{a:8'd1,   b:8'd254, rest:8'd3,   stall_beat:0,  stall_len:0,  ea:8'd1,   eb:8'd254, erest:8'd3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_oValid", oValid, 1'b0);
    check("rst_oLast",  oLast,  1'b0);
    check("rst_oBit",   oBit,   '0);
    check("rst_rngEn",  rngEn,  1'b0);
    check("rst_iReady", iReady, 1'b1);
    #2 rst_n = 1'b1;

    // Latency from IDLE, mid-range operand on all lanes
    @(posedge clk); #1;
    exp_q.push_back(mk(tbl[0].ea, tbl[0].eb, tbl[0].erest));
    iValid = 1'b1;
    iData  = mk(tbl[0].a, tbl[0].b, tbl[0].rest);
    @(negedge clk) check("lat_ready_t", iReady, 1'b1);
    @(posedge clk); #1;
    iValid = 1'b0;
    check("lat_t_oValid", oValid, 1'b0);
    check("lat_t_iReady", iReady, 1'b0);
    @(posedge clk); #1;
    check("lat_t1_oValid", oValid, 1'b0);
    check("lat_t1_iReady", iReady, 1'b1);
    check("lat_t1_rngEn",  rngEn,  1'b1);
    @(posedge clk); #1;
    check("lat_t2_oValid", oValid, 1'b1);
    wait_streams(1, 0, 0);
    check("idle_oValid", oValid, 1'b0);
    check("idle_rngEn",  rngEn,  1'b0);

    // Table-driven streams: boundary operands, stall at beat 50, small/near-max operands
    for (int t = 1; t < 4; t++) begin
      int target;
      target = streams_done + 1;
      load(mk(tbl[t].a, tbl[t].b, tbl[t].rest), mk(tbl[t].ea, tbl[t].eb, tbl[t].erest));
      wait_streams(target, tbl[t].stall_beat, tbl[t].stall_len);
      repeat (2) @(posedge clk);
      #1 check("table_idle", oValid, 1'b0);
    end

    // Back-to-back: second vector loaded during the first stream
    begin
      int target;
      target = streams_done + 2;
      load(mk(tbl[1].a, tbl[1].b, tbl[1].rest), mk(tbl[1].ea, tbl[1].eb, tbl[1].erest));
      load(mk(tbl[3].a, tbl[3].b, tbl[3].rest), mk(tbl[3].ea, tbl[3].eb, tbl[3].erest));
      wait_streams(target, 0, 0);
    end

    // Full shadow: a junk vector offered while the shadow is full must never be taken
    begin
      int target;
      logic got;
      target = streams_done + 3;
      load(mk(8'd128, 8'd128, 8'd128), mk(8'd128, 8'd128, 8'd128));
      load(mk(8'd10, 8'd20, 8'd30), mk(8'd10, 8'd20, 8'd30));
      exp_q.push_back(mk(8'd250, 8'd5, 8'd99));
      iValid = 1'b1;
      iData  = mk(8'd0, 8'd0, 8'd0);
      for (int k = 0; k < 100; k++) begin
        @(negedge clk) check("shadow_full_block", iReady, 1'b0);
        @(posedge clk) #1 iData = mk(8'(k), 8'(255 - k), 8'(k * 3));
      end
      iData = mk(8'd250, 8'd5, 8'd99);
      got = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk); got = iReady;
        @(posedge clk); #1;
        if (got) break;
      end
      iValid = 1'b0;
      check("shadow_accept_after_promote", got, 1'b1);
      wait_streams(target, 0, 0);
    end

    // Reset mid-stream at beat 100, then a fresh full stream
    begin
      int target;
      load(mk(tbl[1].a, tbl[1].b, tbl[1].rest), mk(tbl[1].ea, tbl[1].eb, tbl[1].erest));
      for (int k = 0; k < 1000; k++) begin
        @(posedge clk); #1;
        if (acc_beats >= 100) break;
      end
      check("reach_beat100", acc_beats >= 100, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst_oValid", oValid, 1'b0);
      check("arst_oLast",  oLast,  1'b0);
      check("arst_iReady", iReady, 1'b1);
      check("arst_rngEn",  rngEn,  1'b0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) @(negedge clk) check("post_reset_quiet", oValid, 1'b0);
      target = streams_done + 1;
      @(posedge clk); #1;
      load(mk(tbl[0].a, tbl[0].b, tbl[0].rest), mk(tbl[0].ea, tbl[0].eb, tbl[0].erest));
      wait_streams(target, 0, 0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
